accumulator_sequencer: RTL
==========================

# accumulator_sequencer

Controller that sequences one external `accumulator` instance over fixed-length sample windows for the spike-feature datapath. On `start` it preloads the accumulator with a bias value, feeds exactly `WINDOW` accepted samples through a valid/ready handshake and gates the accumulator input to zero on idle cycles. It then captures the final sum and a sticky overflow flag, and presents them on a valid/ready output to the decision-tree comparator stage.

## Interface
- `IN_WIDTH`, 14, sample width (signed); accumulator/result width is `IN_WIDTH+1`
- `WINDOW`, 16, samples per window, ≥1; counter width `$clog2(WINDOW+1)`
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a window; honoured only in IDLE
- `init`  in  IN_WIDTH+1  bias, sampled on the accepted `start` cycle
- `in_valid`  in  1  sample present
- `in_data`  in  IN_WIDTH  signed sample
- `in_ready`  out  1  sequencer accepts the sample this cycle
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream takes the result
- `result`  out  IN_WIDTH+1  window sum (two's-complement wrap)
- `result_ovf`  out  1  at least one addition in the window overflowed
- `busy`  out  1  state ≠ IDLE
- `acc_load`  out  1  to accumulator `load`
- `acc_init`  out  IN_WIDTH+1  to accumulator `init`
- `acc_a`  out  IN_WIDTH  to accumulator `a`
- `acc_y`  in  IN_WIDTH+1  from accumulator `y`
- `acc_overflow`  in  1  from accumulator `overflow` (combinational, current addition)

## Operation
- States: IDLE → LOAD → ACCUM → CAPTURE → HOLD → IDLE (or → LOAD with `ACC_AUTO_RESTART_EN`).
- IDLE: `start`=1 latches `init` into `init_reg`, clears `ovf_sticky` and `count`, goes to LOAD. `start` in any other state is ignored.
- LOAD: `acc_load`=1, `acc_init`=`init_reg`, `acc_a`=0. Unconditionally goes to ACCUM.
- ACCUM:
  - `in_ready`=1.
  - Accept = `in_valid & in_ready`.
  - On accept: `acc_a`=`in_data`, `count`++, and `ovf_sticky` |= `acc_overflow`.
  - Not accepting: `acc_a`=0, so the accumulator holds.
  - The accept that brings `count` to `WINDOW` moves the state to CAPTURE.
- CAPTURE: `acc_a`=0. `result` ← `acc_y`, `result_ovf` ← `ovf_sticky`. Goes to HOLD.
- HOLD: `out_valid`=1 and `in_ready`=0. `result`/`result_ovf` stay stable until `out_ready`=1, then the state leaves HOLD.
- Outside LOAD: `acc_load`=0 and `acc_init`=`init_reg`.
- Outside ACCUM: `in_ready`=0 and `acc_a`=0.
- Arithmetic: wrap-around in `IN_WIDTH+1` bits, as produced by the accumulator; the sequencer never saturates. `acc_overflow` is sampled only on accept cycles; overflow on zero-add cycles is impossible.
- Reset (`reset`=0, any time, including mid-window): state=IDLE, `count`=0, `init_reg`=0, `ovf_sticky`=0, `result`=0, `result_ovf`=0. All outputs are 0: `in_ready`, `out_valid`, `busy`, `acc_load`, `acc_init`, `acc_a`. The accumulator is reloaded at the next LOAD, so a stale `acc_y` is harmless.

## Timing
- `start` accepted at cycle t: LOAD at t+1, accumulator holds `init` after the t+1 edge, first possible accept at t+2.
- Minimum window time: `start` → `out_valid` = `WINDOW`+3 cycles with `in_valid` held high.
- Last accept at cycle k: CAPTURE at k+1, `out_valid`=1 from k+2.
- `out_ready` may be high before `out_valid`; the handshake completes in the first HOLD cycle. Next `start` is accepted the cycle after HOLD exits.
- Bubbles on `in_valid` only stretch ACCUM; the count is of accepts, not cycles.

## Configuration
- `ACC_AUTO_RESTART_EN` defined: HOLD with `out_ready`=1 goes directly to LOAD, reusing `init_reg` and clearing `count`/`ovf_sticky`. `busy` stays 1, and `start` is ignored while running. Clearing `start` does not stop the chain; only reset returns to IDLE.
- `ACC_AUTO_RESTART_EN` undefined: HOLD → IDLE, and each window needs its own `start`.

## Test plan
- Reset mid-ACCUM after 5 accepts → next cycle all outputs 0, `busy`=0; a fresh `start` with `init`=0 and 16 samples of 1 gives `result`=16.
- `WINDOW`=16, `init`=100, `in_data`=3 held valid → `out_valid` at `start`+19, `result`=148, `result_ovf`=0.
- `in_valid` toggling 1,0,1,0… with `in_data`=−2 and `init`=0 → `result`=−32, `out_valid` only after the 16th accept.
- `IN_WIDTH`=14, `init`=16383, first sample 1 → wraps to −16384, `result_ovf`=1, and it stays 1 even after the remaining samples of −1 bring the sum back in range.
- `out_ready` held low 10 cycles in HOLD with `start` and `in_valid` pulsed → `result` stable, `in_ready`=0, `start` ignored; release `out_ready` → IDLE next cycle.
- With `ACC_AUTO_RESTART_EN` and `out_ready`=1: three back-to-back windows each report `init`+sum. A window after an overflowing window reports `result_ovf`=0.

Source files
------------

// File: rtl/accumulator_sequencer.sv
// Window sequencer for an external accumulator: bias preload, WINDOW gated accepts, result capture/hold.
// Optional build macro ACC_AUTO_RESTART_EN chains windows back-to-back after each result handshake.
module accumulator_sequencer #(
    parameter int IN_WIDTH = 14,
    parameter int WINDOW   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH:0]   init,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IN_WIDTH:0]   result,
    output logic                result_ovf,
    output logic                busy,
    output logic                acc_load,
    output logic [IN_WIDTH:0]   acc_init,
    output logic [IN_WIDTH-1:0] acc_a,
    input  logic [IN_WIDTH:0]   acc_y,
    input  logic                acc_overflow
);

    // state   | meaning
    // IDLE    | waiting for start
    // LOAD    | accumulator preloaded with init_reg
    // ACCUM   | accepting samples until WINDOW accepts
    // CAPTURE | latch acc_y and sticky overflow into result
    // HOLD    | result presented until out_ready

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WINDOW - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ACCUM   = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       count;
    logic [IN_WIDTH:0]   init_reg;
    logic                ovf_sticky;
    logic                accept;
    logic                clear_win;
    logic                take_init;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        acc_load  = 1'b0;
        acc_a     = '0;
        accept    = 1'b0;
        clear_win = 1'b0;
        take_init = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    take_init = 1'b1;
                    clear_win = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                acc_load  = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    acc_a = in_data;
                    if (count == LAST_COUNT) begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef ACC_AUTO_RESTART_EN
                    clear_win = 1'b1;
                    state_nxt = LOAD;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign acc_init = init_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            init_reg   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (take_init) begin
                init_reg <= init;
            end
            if (clear_win) begin
                count      <= '0;
                ovf_sticky <= 1'b0;
            end else if (accept) begin
                count      <= count + 1'b1;
                ovf_sticky <= ovf_sticky | acc_overflow;
            end
        end
    end

    // acc_y already includes the final accepted sample once CAPTURE is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result     <= '0;
            result_ovf <= 1'b0;
        end else if (state == CAPTURE) begin
            result     <= acc_y;
            result_ovf <= ovf_sticky;
        end
    end

endmodule
